freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 17 +
 rtl/freq_meter_edge_sync.sv | 37 +++
 rtl/freq_meter.sv | 184 ++++++++++++++++++
 tb/tb_freq_meter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared encodings for the frequency/period meter.
//   mode_e  : measurement mode as presented on the mode input pin
//   state_e : control FSM states
package freq_meter_pkg;

  typedef enum logic {
    MODE_FREQ   = 1'b0,
    MODE_PERIOD = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk        : destination clock
//   rst_n      : asynchronous active-low reset
//   async_in   : signal asynchronous to clk
//   rise_pulse : one-cycle pulse for each rising edge of async_in
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Multi-channel frequency / period meter.
//   clk, rst_n : reference clock, asynchronous active-low reset
//   meas_clk   : NUM_CH measured clocks (asynchronous to clk)
//   start/stop : begin / abort a measurement (stop also ends continuous mode)
//   mode, cont : FREQ or PERIOD measurement, continuous or single shot
//   gate_len   : window length (FREQ) or timeout (PERIOD) in clk cycles
//   busy       : measurement in progress
//   res_valid  : one-cycle pulse, results below updated in the same cycle
//   res_data   : per-channel result, channel i at [i*CNT_W +: CNT_W]
//   res_ovf    : per-channel saturation flag
//   res_tmo    : per-channel PERIOD timeout flag
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       meas_clk,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic                    cont,
  input  logic [GATE_W-1:0]       gate_len,
  output logic                    busy,
  output logic                    res_valid,
  output logic [NUM_CH*CNT_W-1:0] res_data,
  output logic [NUM_CH-1:0]       res_ovf,
  output logic [NUM_CH-1:0]       res_tmo
);

  logic [NUM_CH-1:0] rise;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    edge_sync u_edge_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (meas_clk[g]),
      .rise_pulse (rise[g])
    );
  end

  state_e                         state_q, state_d;
  mode_e                          mode_q, mode_d;
  logic                           cont_q, cont_d;
  logic [GATE_W-1:0]              glen_q, glen_d;
  logic [GATE_W-1:0]              gcnt_q, gcnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              ovf_q, ovf_d;
  logic [NUM_CH-1:0]              armed_q, armed_d;
  logic [NUM_CH-1:0]              frozen_q, frozen_d;
  logic                           res_valid_q, res_valid_d;
  logic [NUM_CH*CNT_W-1:0]        res_data_q, res_data_d;
  logic [NUM_CH-1:0]              res_ovf_q, res_ovf_d;
  logic [NUM_CH-1:0]              res_tmo_q, res_tmo_d;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cont_d      = cont_q;
    glen_d      = glen_q;
    gcnt_d      = gcnt_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    armed_d     = armed_q;
    frozen_d    = frozen_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_tmo_d   = res_tmo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode_e'(mode);
          cont_d   = cont;
          glen_d   = (gate_len == '0) ? GATE_W'(1) : gate_len;
          gcnt_d   = glen_d;
          cnt_d    = '0;
          ovf_d    = '0;
          armed_d  = '0;
          frozen_d = '0;
          state_d  = MEASURE;
        end
      end

      MEASURE: begin
        gcnt_d = gcnt_q - 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (mode_q == MODE_FREQ) begin
            if (rise[i]) begin
              if (cnt_q[i] == '1) ovf_d[i] = 1'b1;
              else                cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end else if (!frozen_q[i]) begin
            if (armed_q[i]) begin
              // the freezing cycle itself still counts: result = edge spacing
              if (cnt_q[i] == '1) ovf_d[i] = 1'b1;
              else                cnt_d[i] = cnt_q[i] + 1'b1;
              if (rise[i]) frozen_d[i] = 1'b1;
            end else if (rise[i]) begin
              armed_d[i] = 1'b1;
            end
          end
        end

        if (stop) begin
          state_d = IDLE;
        end else if ((gcnt_d == '0) || ((mode_q == MODE_PERIOD) && (&frozen_d))) begin
          // results are registered on the way into DONE so they line up with res_valid
          state_d     = DONE;
          res_valid_d = 1'b1;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ((mode_q == MODE_PERIOD) && !frozen_d[i]) begin
              res_data_d[i*CNT_W +: CNT_W] = '0;
              res_ovf_d[i]                 = 1'b0;
              res_tmo_d[i]                 = 1'b1;
            end else begin
              res_data_d[i*CNT_W +: CNT_W] = cnt_d[i];
              res_ovf_d[i]                 = ovf_d[i];
              res_tmo_d[i]                 = 1'b0;
            end
          end
        end
      end

      DONE: begin
        if (cont_q && !stop) begin
          gcnt_d   = glen_q;
          cnt_d    = '0;
          ovf_d    = '0;
          armed_d  = '0;
          frozen_d = '0;
          state_d  = MEASURE;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_FREQ;
      cont_q      <= 1'b0;
      glen_q      <= '0;
      gcnt_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= '0;
      armed_q     <= '0;
      frozen_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= '0;
      res_tmo_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cont_q      <= cont_d;
      glen_q      <= glen_d;
      gcnt_q      <= gcnt_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      armed_q     <= armed_d;
      frozen_q    <= frozen_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_tmo_q   <= res_tmo_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_tmo   = res_tmo_q;

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic        cont = 1'b0;
  logic [15:0] gate_len = '0;
  logic [NCH-1:0] meas_clk;

  logic        busy, res_valid;
  logic [63:0] res_data;
  logic [3:0]  res_ovf, res_tmo;
  logic        busy8, res_valid8;
  logic [31:0] res_data8;
  logic [3:0]  res_ovf8, res_tmo8;

  int total = 0;
  int bad = 0;

  int          hp [NCH] = '{20, 25, 50, 100};
  logic [NCH-1:0] en = '1;
  longint      edge_q [NCH][$];

  freq_meter #(.NUM_CH(4), .CNT_W(16), .GATE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk), .start(start), .stop(stop),
    .mode(mode), .cont(cont), .gate_len(gate_len), .busy(busy), .res_valid(res_valid),
    .res_data(res_data), .res_ovf(res_ovf), .res_tmo(res_tmo)
  );

  freq_meter #(.NUM_CH(4), .CNT_W(8), .GATE_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk), .start(start), .stop(stop),
    .mode(mode), .cont(cont), .gate_len(gate_len), .busy(busy8), .res_valid(res_valid8),
    .res_data(res_data8), .res_ovf(res_ovf8), .res_tmo(res_tmo8)
  );

  // clk rises at 5 + 10k ns; measured-clock edges never land on a multiple of 5 ns
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_mc
    logic m = 1'b0;
    assign meas_clk[g] = m;
    initial begin
      #($urandom_range(1, 4) + 5 * $urandom_range(0, 1));
      forever begin
        #(hp[g]);
        if (en[g]) m = ~m;
        else       m = 1'b0;
      end
    end
    always @(posedge m) edge_q[g].push_back($time);
  end

  // clk edge at which an input edge at time t bumps a counter: 3rd rising clk edge after t
  function automatic longint count_time(longint t);
    return 10 * ((t + 5) / 10) + 25;
  endfunction

  // edges whose counting clk edge lies in the gate (t0 = edge that sampled start)
  function automatic int model_freq(int ch, longint t0, int n);
    int c = 0;
    for (int k = 0; k < edge_q[ch].size(); k++) begin
      longint ct = count_time(edge_q[ch][k]);
      if (ct >= t0 + 10 && ct <= t0 + 10 * n) c++;
    end
    return c;
  endfunction

  task automatic model_period(input int ch, input longint t0, input int n,
                              output bit fr, output longint t_fr, output int val);
    longint first = -1;
    fr = 1'b0; t_fr = 0; val = 0;
    for (int k = 0; k < edge_q[ch].size(); k++) begin
      longint ct = count_time(edge_q[ch][k]);
      if (ct < t0 + 10 || ct > t0 + 10 * n) continue;
      if (first < 0) first = ct;
      else begin
        fr = 1'b1; t_fr = ct; val = int'((ct - first) / 10);
        break;
      end
    end
  endtask

  task automatic do_start(output longint t0);
    start = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit got, output longint t_edge);
    got = 1'b0; t_edge = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) begin
        got = 1'b1; t_edge = $time - 1;
        return;
      end
    end
  endtask

  task automatic count_valid(input int ncyc, output int n);
    n = 0;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) n++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %0b expected 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset res_valid: got %0b expected 0", res_valid); end
    total++; if (res_data !== 64'd0) begin bad++; $display("FAIL reset res_data: got %0h expected 0", res_data); end
    total++; if ({res_ovf, res_tmo} !== 8'd0) begin bad++; $display("FAIL reset flags: got %0h expected 0", {res_ovf, res_tmo}); end
    total++; if ({busy8, res_valid8, res_data8, res_ovf8, res_tmo8} !== '0) begin bad++; $display("FAIL reset dut8: got %0h expected 0", res_data8); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(5);
  endtask

  task automatic run_freq(input string name, input int n, input bit check_nominal);
    longint t0, te; bit got; int nv, exp8;
    mode = 1'b0; cont = 1'b0; gate_len = 16'(n);
    idle_cycles(30);
    do_start(t0);
    wait_valid(n + 20, got, te);
    total++;
    if (!got) begin bad++; $display("FAIL %s timeout: got no res_valid expected one", name); return; end
    total++; if (te != t0 + 10 * n) begin bad++; $display("FAIL %s valid time: got %0d expected %0d", name, te, t0 + 10 * n); end
    for (int ch = 0; ch < NCH; ch++) begin
      int e = model_freq(ch, t0, n);
      int a = int'(res_data[ch*16 +: 16]);
      exp8 = (e > 255) ? 255 : e;
      total++; if (a != e) begin bad++; $display("FAIL %s data ch%0d: got %0d expected %0d", name, ch, a, e); end
      total++; if (res_ovf[ch] !== 1'b0 || res_tmo[ch] !== 1'b0) begin bad++; $display("FAIL %s flags ch%0d: got ovf=%0b tmo=%0b expected 0 0", name, ch, res_ovf[ch], res_tmo[ch]); end
      total++; if (int'(res_data8[ch*8 +: 8]) != exp8 || res_ovf8[ch] !== (e > 255)) begin bad++; $display("FAIL %s 8bit ch%0d: got %0d/%0b expected %0d/%0b", name, ch, res_data8[ch*8 +: 8], res_ovf8[ch], exp8, e > 255); end
      if (check_nominal) begin
        int nom = (n * 10) / (2 * hp[ch]);
        total++; if (a < nom - 1 || a > nom + 1) begin bad++; $display("FAIL %s nominal ch%0d: got %0d expected %0d+-1", name, ch, a, nom); end
      end
    end
    count_valid(40, nv);
    total++; if (nv != 0 || busy !== 1'b0) begin bad++; $display("FAIL %s single shot: got %0d extra pulses busy=%0b expected 0 0", name, nv, busy); end
  endtask

  task automatic test_freq;
    hp = '{20, 25, 50, 100}; en = '1;
    run_freq("freq_directed", 1000, 1'b1);
    for (int it = 0; it < 3; it++) begin
      for (int ch = 0; ch < NCH; ch++) hp[ch] = 5 * int'($urandom_range(2, 20));
      run_freq("freq_random", int'($urandom_range(1, 400)), 1'b0);
    end
  endtask

  task automatic test_overflow;
    hp[0] = 10; en = '1;
    run_freq("ovf", 1000, 1'b0);
    total++; if (res_data8[7:0] !== 8'd255 || res_ovf8[0] !== 1'b1) begin bad++; $display("FAIL ovf ch0 8bit: got %0d/%0b expected 255/1", res_data8[7:0], res_ovf8[0]); end
  endtask

  task automatic run_period(input string name, input int n);
    longint t0, te, t_end; bit got; bit fr [NCH]; longint tf [NCH]; int val [NCH]; bit all_fr;
    mode = 1'b1; cont = 1'b0; gate_len = 16'(n);
    idle_cycles(30);
    do_start(t0);
    wait_valid(n + 20, got, te);
    total++;
    if (!got) begin bad++; $display("FAIL %s timeout: got no res_valid expected one", name); return; end
    all_fr = 1'b1; t_end = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      model_period(ch, t0, n, fr[ch], tf[ch], val[ch]);
      if (!fr[ch]) all_fr = 1'b0;
      else if (tf[ch] > t_end) t_end = tf[ch];
    end
    if (!all_fr) t_end = t0 + 10 * n;
    total++; if (te != t_end) begin bad++; $display("FAIL %s valid time: got %0d expected %0d", name, te, t_end); end
    for (int ch = 0; ch < NCH; ch++) begin
      int a = int'(res_data[ch*16 +: 16]);
      int e = fr[ch] ? val[ch] : 0;
      total++; if (a != e) begin bad++; $display("FAIL %s data ch%0d: got %0d expected %0d", name, ch, a, e); end
      total++; if (res_tmo[ch] !== !fr[ch] || res_ovf[ch] !== 1'b0) begin bad++; $display("FAIL %s flags ch%0d: got tmo=%0b ovf=%0b expected %0b 0", name, ch, res_tmo[ch], res_ovf[ch], !fr[ch]); end
    end
  endtask

  task automatic test_period;
    hp[0] = 25; en = 4'b0001;
    run_period("period_directed", 100);
    total++; if (res_data[15:0] !== 16'd5) begin bad++; $display("FAIL period ch0 literal: got %0d expected 5", res_data[15:0]); end
    for (int it = 0; it < 3; it++) begin
      for (int ch = 0; ch < NCH; ch++) hp[ch] = 5 * int'($urandom_range(2, 12));
      en = (it == 0) ? 4'b1111 : 4'($urandom_range(1, 15));
      run_period("period_random", int'($urandom_range(60, 300)));
    end
  endtask

  task automatic test_continuous;
    longint t0, te; bit got; int nv; logic [63:0] held;
    en = '1;
    for (int ch = 0; ch < NCH; ch++) hp[ch] = 5 * int'($urandom_range(2, 20));
    mode = 1'b0; cont = 1'b1; gate_len = 16'd50;
    idle_cycles(30);
    do_start(t0);
    cont = 1'b0;
    for (int w = 0; w < 3; w++) begin
      longint tw = t0 + w * 510;
      wait_valid(70, got, te);
      total++;
      if (!got) begin bad++; $display("FAIL cont window%0d: got no res_valid expected one", w); return; end
      total++; if (te != tw + 500) begin bad++; $display("FAIL cont spacing window%0d: got %0d expected %0d", w, te, tw + 500); end
      for (int ch = 0; ch < NCH; ch++) begin
        int e = model_freq(ch, tw, 50);
        total++; if (int'(res_data[ch*16 +: 16]) != e) begin bad++; $display("FAIL cont data w%0d ch%0d: got %0d expected %0d", w, ch, res_data[ch*16 +: 16], e); end
      end
    end
    idle_cycles(20);
    held = res_data;
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont stop busy: got %0b expected 0", busy); end
    count_valid(150, nv);
    total++; if (nv != 0) begin bad++; $display("FAIL cont stop pulses: got %0d expected 0", nv); end
    total++; if (res_data !== held) begin bad++; $display("FAIL cont stop data held: got %0h expected %0h", res_data, held); end
  endtask

  task automatic test_stop_at_done;
    longint t0, te; bit got; int nv;
    mode = 1'b0; cont = 1'b1; gate_len = 16'($urandom_range(10, 40));
    idle_cycles(5);
    do_start(t0);
    wait_valid(60, got, te);
    total++; if (!got) begin bad++; $display("FAIL stop_at_done: got no res_valid expected one"); end
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    cont = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_at_done busy: got %0b expected 0", busy); end
    count_valid(100, nv);
    total++; if (nv != 0) begin bad++; $display("FAIL stop_at_done pulses: got %0d expected 0", nv); end
  endtask

  task automatic test_reset_mid;
    longint t0; int nv;
    mode = 1'b0; cont = 1'b0; gate_len = 16'd100;
    idle_cycles(5);
    do_start(t0);
    repeat (29) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL reset_mid ctrl: got busy=%0b valid=%0b expected 0 0", busy, res_valid); end
    total++; if (res_data !== 64'd0 || res_ovf !== 4'd0 || res_tmo !== 4'd0) begin bad++; $display("FAIL reset_mid results: got %0h expected 0", res_data); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    count_valid(200, nv);
    total++; if (nv != 0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid after release: got %0d pulses busy=%0b expected 0 0", nv, busy); end
  endtask

  task automatic test_start_busy_gate0;
    longint t0, te; bit got; int nv;
    mode = 1'b0; cont = 1'b0; gate_len = 16'd20;
    idle_cycles(10);
    do_start(t0);
    idle_cycles(4);
    gate_len = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(40, got, te);
    total++; if (!got || te != t0 + 200) begin bad++; $display("FAIL start_while_busy valid: got %0d expected %0d", te, t0 + 200); end
    for (int ch = 0; ch < NCH; ch++) begin
      int e = model_freq(ch, t0, 20);
      total++; if (int'(res_data[ch*16 +: 16]) != e) begin bad++; $display("FAIL start_while_busy data ch%0d: got %0d expected %0d", ch, res_data[ch*16 +: 16], e); end
    end
    count_valid(30, nv);
    total++; if (nv != 0) begin bad++; $display("FAIL start_while_busy pulses: got %0d expected 0", nv); end
    gate_len = 16'd0;
    do_start(t0);
    wait_valid(5, got, te);
    total++; if (!got || te != t0 + 10) begin bad++; $display("FAIL gate0 valid: got %0d expected %0d", te, t0 + 10); end
    for (int ch = 0; ch < NCH; ch++) begin
      int e = model_freq(ch, t0, 1);
      total++; if (int'(res_data[ch*16 +: 16]) != e) begin bad++; $display("FAIL gate0 data ch%0d: got %0d expected %0d", ch, res_data[ch*16 +: 16], e); end
    end
  endtask

  initial begin
    test_reset();
    test_freq();
    test_overflow();
    test_period();
    test_continuous();
    test_stop_at_done();
    test_reset_mid();
    test_start_busy_gate0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
